// File: rtl/trace_shim_pkg.sv
// ---------------------------------------------------------------------------
// trace_shim_pkg
//   Shared definitions for the trace shim slice:
//     - state_t    : shim FSM encodings (IDLE/RUN/STEP/HALT)
//     - STARVE_W   : width of the saturating starve counter
//     - calc_tr_w  : trace record width. It depends on whether the build
//                    defines TRACE_STAMP_EN, which adds the cycle stamp.
// ---------------------------------------------------------------------------
package trace_shim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam int STARVE_W = 8;

  // Record layout is {stamp, cjump, io_out} with the stamp, and
  // {cjump, io_out} without it.
  function automatic int calc_tr_w(input int out_w, input int stamp_w);
`ifdef TRACE_STAMP_EN
    return stamp_w + 1 + out_w;
`else
    // stamp_w has no effect in this build. It stays in the signature so
    // callers are the same in both builds.
    return 1 + out_w + (stamp_w - stamp_w);
`endif
  endfunction

endpackage

// File: rtl/trace_shim_if.sv
// ---------------------------------------------------------------------------
// trace_shim_if
//   Host-side bundle of the trace shim. It carries two streams:
//     - instruction stream host->shim : in_valid / in_ready / in_instr
//     - trace stream shim->host       : tr_valid / tr_ready / tr_data
//   Modports:
//     master : host or testbench (drives in_valid, in_instr, tr_ready)
//     slave  : trace_shim        (drives in_ready, tr_valid, tr_data)
//   The TR_W default matches OUT_W=5 and STAMP_W=8 for the active build.
// ---------------------------------------------------------------------------
interface trace_shim_if
  import trace_shim_pkg::*;
#(
  parameter int INSTR_W = 6,
  parameter int TR_W    = calc_tr_w(5, 8)
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  logic               tr_valid;
  logic               tr_ready;
  logic [TR_W-1:0]    tr_data;

  modport master (
    output in_valid, in_instr, tr_ready,
    input  in_ready, tr_valid, tr_data
  );

  modport slave (
    input  in_valid, in_instr, tr_ready,
    output in_ready, tr_valid, tr_data
  );

endinterface

// File: rtl/trace_shim_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO. The trace shim uses two of them: one for
//   instructions and one for trace records.
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     push, din      write request and data. A write is taken when the
//                    FIFO is not full, or when a read happens in the same
//                    cycle.
//     pop            read request. It has no effect while the FIFO is empty.
//     dout           head entry. It reads as 0 while the FIFO is empty.
//     full, empty    decoded from the registered count only
//     count          number of stored entries (0..DEPTH)
//   DEPTH must be a power of two and at least 2. The pointers wrap
//   naturally at that width.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  assign rd_en = pop && !empty;
  // A full FIFO can still take a write when a read frees a slot in the
  // same cycle.
  assign wr_en = push && (!full || rd_en);

  // Storage has no reset. Only entries between the pointers are
  // meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The head is masked while empty so the output is 0 after reset.
  assign dout = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/trace_shim.sv
// ---------------------------------------------------------------------------
// trace_shim
//   Sits between a host and the tiny CPU core. The host queues
//   instructions. The shim issues them to the core in RUN mode, or one at a
//   time in STEP mode. It records every io_out change and every cjump pulse
//   into a trace FIFO that the host can read later.
//
//   Optional feature: when TRACE_STAMP_EN is defined, each record also
//   carries a cycle stamp that counts non-IDLE cycles. Records are then
//   {stamp, cjump, io_out}. Without it, records are {cjump, io_out}.
//
//   Ports:
//     clk, rst               clock, asynchronous active-low reset
//     ctl_run                level: issue continuously while high
//     ctl_step               level: each rising edge issues one slot
//     ctl_clr                pulse: clears overflow and starve_cnt
//     host (slave modport)   instruction input stream, trace output stream
//     dut_instr              registered instruction driven to the core
//     dut_io_out, dut_cjump  core activity that is observed
//     overflow               sticky: a trace record was dropped
//     starve_cnt             saturating count of issue slots with no
//                            instruction available
//     state_o                FSM state, for debug
// ---------------------------------------------------------------------------
module trace_shim
  import trace_shim_pkg::*;
#(
  parameter int                 INSTR_W     = 6,
  parameter int                 OUT_W       = 5,
  parameter int                 IFIFO_DEPTH = 8,
  parameter int                 TFIFO_DEPTH = 8,
  parameter int                 STAMP_W     = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctl_run,
  input  logic                ctl_step,
  input  logic                ctl_clr,
  trace_shim_if.slave         host,
  output logic [INSTR_W-1:0]  dut_instr,
  input  logic [OUT_W-1:0]    dut_io_out,
  input  logic                dut_cjump,
  output logic                overflow,
  output logic [STARVE_W-1:0] starve_cnt,
  output logic [1:0]          state_o
);

  localparam int TR_W = calc_tr_w(OUT_W, STAMP_W);

  state_t               state_reg;
  state_t               state_next;
  logic                 step_prev_reg;
  logic                 step_rise;
  logic [INSTR_W-1:0]   instr_reg;
  logic [OUT_W-1:0]     last_io_reg;
  logic                 overflow_reg;
  logic [STARVE_W-1:0]  starve_reg;

  // Instruction FIFO wiring
  logic                 ipush;
  logic                 ipop;
  logic [INSTR_W-1:0]   idout;
  logic                 ifull;
  logic                 iempty;
  logic [$clog2(IFIFO_DEPTH):0] icount;

  // Trace FIFO wiring
  logic                 tpush;
  logic [TR_W-1:0]      rec_data;
  logic                 tfull;
  logic                 tempty;
  logic [$clog2(TFIFO_DEPTH):0] tcount;

  logic                 issue_slot;
  logic                 starve;
  logic                 active;
  logic                 drop;

  // Only full/empty drive control. The counts exist for debug.
  logic                 unused_counts;
  assign unused_counts = ^{icount, tcount};

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  assign step_rise = ctl_step && !step_prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      step_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_prev_reg <= ctl_step;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // If both arrive together, ctl_run takes priority over a step edge.
        if (ctl_run)        state_next = ST_RUN;
        else if (step_rise) state_next = ST_STEP;
      end
      ST_RUN: begin
        if (!ctl_run) state_next = ST_IDLE;
      end
      ST_STEP: begin
        state_next = ST_HALT;
      end
      ST_HALT: begin
        // Stay here until the step level drops. A held ctl_step then
        // cannot re-trigger.
        if (ctl_run)        state_next = ST_RUN;
        else if (!ctl_step) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign state_o = state_reg;

  // -------------------------------------------------------------------------
  // Issue path: a pop in cycle N is registered and reaches the core in N+1.
  // -------------------------------------------------------------------------
  assign issue_slot = (state_reg == ST_RUN) || (state_reg == ST_STEP);
  assign ipop       = issue_slot && !iempty;
  assign starve     = issue_slot && iempty;
  assign ipush      = host.in_valid && !ifull;
  assign host.in_ready = !ifull;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (IFIFO_DEPTH)
  ) u_ififo (
    .clk   (clk),
    .rst   (rst),
    .push  (ipush),
    .din   (host.in_instr),
    .pop   (ipop),
    .dout  (idout),
    .full  (ifull),
    .empty (iempty),
    .count (icount)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_reg <= NOP_INSTR;
    end else begin
      instr_reg <= ipop ? idout : NOP_INSTR;
    end
  end

  assign dut_instr = instr_reg;

  // -------------------------------------------------------------------------
  // Status: ctl_clr takes priority over a same-cycle starve or drop event.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (ctl_clr)
        starve_reg <= '0;
      else if (starve && (starve_reg != '1))
        starve_reg <= starve_reg + 1'b1;

      if (ctl_clr)
        overflow_reg <= 1'b0;
      else if (drop)
        overflow_reg <= 1'b1;
    end
  end

  assign starve_cnt = starve_reg;
  assign overflow   = overflow_reg;

  // -------------------------------------------------------------------------
  // Trace capture. Nothing is captured in IDLE.
  // -------------------------------------------------------------------------
  assign active = (state_reg != ST_IDLE);
  assign tpush  = active && ((dut_io_out != last_io_reg) || dut_cjump);
  // The FIFO takes a record while full only if the host pops in the same
  // cycle. Full implies non-empty, so tr_ready alone means a pop.
  assign drop   = tpush && tfull && !host.tr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_io_reg <= '0;
    end else if (active) begin
      last_io_reg <= dut_io_out;
    end
  end

`ifdef TRACE_STAMP_EN
  logic [STAMP_W-1:0] stamp_reg;

  // Counts non-IDLE cycles. It wraps, and only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_reg <= '0;
    end else if (active) begin
      stamp_reg <= stamp_reg + 1'b1;
    end
  end

  assign rec_data = {stamp_reg, dut_cjump, dut_io_out};
`else
  assign rec_data = {dut_cjump, dut_io_out};
`endif

  sync_fifo #(
    .WIDTH (TR_W),
    .DEPTH (TFIFO_DEPTH)
  ) u_tfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tpush),
    .din   (rec_data),
    .pop   (host.tr_ready),
    .dout  (host.tr_data),
    .full  (tfull),
    .empty (tempty),
    .count (tcount)
  );

  assign host.tr_valid = !tempty;

endmodule

// File: tb/tb_trace_shim.sv
// ---------------------------------------------------------------------------
// tb_trace_shim
//   Directed testbench for trace_shim. Every expected value is written out
//   by hand. Inputs are driven and outputs sampled 1 ns after each rising
//   clock edge.
// ---------------------------------------------------------------------------
module tb_trace_shim;
  import trace_shim_pkg::*;

  localparam int TR_W = calc_tr_w(5, 8);

  logic                clk = 1'b0;
  logic                rst;
  logic                ctl_run;
  logic                ctl_step;
  logic                ctl_clr;
  logic [5:0]          dut_instr;
  logic [4:0]          io;
  logic                cj;
  logic                overflow;
  logic [STARVE_W-1:0] starve_cnt;
  logic [1:0]          state_o;

  int n_cmp = 0;
  int n_err = 0;

  trace_shim_if #(.INSTR_W(6), .TR_W(TR_W)) hif ();

  trace_shim #(
    .INSTR_W     (6),
    .OUT_W       (5),
    .IFIFO_DEPTH (8),
    .TFIFO_DEPTH (8),
    .STAMP_W     (8),
    .NOP_INSTR   (6'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctl_run    (ctl_run),
    .ctl_step   (ctl_step),
    .ctl_clr    (ctl_clr),
    .host       (hif),
    .dut_instr  (dut_instr),
    .dut_io_out (io),
    .dut_cjump  (cj),
    .overflow   (overflow),
    .starve_cnt (starve_cnt),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [5:0] v);
    hif.in_valid = 1'b1;
    hif.in_instr = v;
    tick();
    hif.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  function automatic logic [TR_W-1:0] mk_rec(input logic [7:0] stamp, input logic c, input logic [4:0] v);
`ifdef TRACE_STAMP_EN
    return {stamp, c, v};
`else
    return TR_W'({c, v}) | TR_W'(stamp & 8'h00);
`endif
  endfunction

  // Checks the head record, then consumes it with one tr_ready cycle.
  task automatic pop_rec(input string tag, input logic [TR_W-1:0] exp);
    check_eq({tag, " valid"}, 32'(hif.tr_valid), 32'd1);
    check_eq({tag, " data"}, 32'(hif.tr_data), 32'(exp));
    hif.tr_ready = 1'b1;
    tick();
    hif.tr_ready = 1'b0;
  endtask

  logic [4:0] io_v [5] = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd7};
  logic       cj_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [5:0] drain_v [8] = '{6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h30, 6'h00};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ctl_run = 1'b0; ctl_step = 1'b0; ctl_clr = 1'b0;
    hif.in_valid = 1'b0; hif.in_instr = '0; hif.tr_ready = 1'b0;
    io = '0; cj = 1'b0;
    repeat (3) tick();

    // Values while reset is held
    check_eq("rst state", 32'(state_o), 32'd0);
    check_eq("rst dut_instr", 32'(dut_instr), 32'd0);
    check_eq("rst in_ready", 32'(hif.in_ready), 32'd1);
    check_eq("rst tr_valid", 32'(hif.tr_valid), 32'd0);
    check_eq("rst tr_data", 32'(hif.tr_data), 32'd0);
    check_eq("rst overflow", 32'(overflow), 32'd0);
    check_eq("rst starve", 32'(starve_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Scenario 1: queue three instructions, then run until the FIFO starves
    push_instr(6'h11);
    push_instr(6'h22);
    push_instr(6'h33);
    ctl_run = 1'b1;
    tick();
    check_eq("s1 state run", 32'(state_o), 32'd1);
    check_eq("s1 nop before pop", 32'(dut_instr), 32'd0);
    tick(); check_eq("s1 issue0", 32'(dut_instr), 32'h11);
    tick(); check_eq("s1 issue1", 32'(dut_instr), 32'h22);
    tick(); check_eq("s1 issue2", 32'(dut_instr), 32'h33);
    tick();
    check_eq("s1 starve nop", 32'(dut_instr), 32'd0);
    check_eq("s1 starve1", 32'(starve_cnt), 32'd1);
    tick(); check_eq("s1 starve2", 32'(starve_cnt), 32'd2);
    ctl_run = 1'b0;
    tick(); tick();
    check_eq("s1 idle", 32'(state_o), 32'd0);
    check_eq("s1 starve3 hold", 32'(starve_cnt), 32'd3);
    check_eq("s1 no trace", 32'(hif.tr_valid), 32'd0);
    ctl_clr = 1'b1; tick(); ctl_clr = 1'b0;
    check_eq("s1 clr starve", 32'(starve_cnt), 32'd0);

    // starve_cnt saturates; ctl_clr wins over a same-cycle starve event
    ctl_run = 1'b1;
    repeat (300) tick();
    check_eq("sat starve", 32'(starve_cnt), 32'd255);
    ctl_clr = 1'b1; tick(); ctl_clr = 1'b0;
    check_eq("clr beats starve", 32'(starve_cnt), 32'd0);
    ctl_run = 1'b0;
    tick(); tick();
    ctl_clr = 1'b1; tick(); ctl_clr = 1'b0;

    // Scenario 2: single-step
    push_instr(6'h05);
    push_instr(6'h06);
    ctl_step = 1'b1;
    tick(); check_eq("s2 state step", 32'(state_o), 32'd2);
    tick();
    check_eq("s2 state halt", 32'(state_o), 32'd3);
    check_eq("s2 issue 05", 32'(dut_instr), 32'h05);
    tick();
    check_eq("s2 halt hold", 32'(state_o), 32'd3);
    check_eq("s2 halt nop", 32'(dut_instr), 32'd0);
    ctl_step = 1'b0;
    tick(); check_eq("s2 back idle", 32'(state_o), 32'd0);
    ctl_step = 1'b1;
    tick(); tick();
    check_eq("s2 issue 06", 32'(dut_instr), 32'h06);
    ctl_step = 1'b0;
    tick();
    check_eq("s2 idle again", 32'(state_o), 32'd0);
    check_eq("s2 no starve", 32'(starve_cnt), 32'd0);

    // Scenario 3: trace capture. Stamps start at 0 on the first RUN cycle.
    do_reset();
    ctl_run = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      io = io_v[i];
      cj = cj_v[i];
      tick();
    end
    cj = 1'b0;
    ctl_run = 1'b0;
    tick(); tick();
    check_eq("s3 head stable", 32'(hif.tr_data), 32'(mk_rec(8'd2, 1'b0, 5'd3)));
    pop_rec("s3 rec0", mk_rec(8'd2, 1'b0, 5'd3));
    pop_rec("s3 rec1", mk_rec(8'd3, 1'b1, 5'd3));
    pop_rec("s3 rec2", mk_rec(8'd4, 1'b0, 5'd7));
    check_eq("s3 drained", 32'(hif.tr_valid), 32'd0);

    // Scenario 4: overflow. 10 changes, 8 entries, no readout.
    io = '0;
    do_reset();
    ctl_run = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      io = 5'(i);
      tick();
    end
    ctl_run = 1'b0;
    tick(); tick();
    check_eq("s4 overflow", 32'(overflow), 32'd1);
    ctl_clr = 1'b1; tick(); ctl_clr = 1'b0;
    check_eq("s4 clr overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      pop_rec($sformatf("s4 rec%0d", k), mk_rec(8'(k), 1'b0, 5'(k + 1)));
    end
    check_eq("s4 drained", 32'(hif.tr_valid), 32'd0);

    // Scenario 5: full instruction FIFO, push and pop together, mid-run reset
    io = '0;
    do_reset();
    for (int i = 0; i < 8; i++) push_instr(6'h20 + 6'(i));
    check_eq("s5 full", 32'(hif.in_ready), 32'd0);
    hif.in_valid = 1'b1;
    hif.in_instr = 6'h30;
    ctl_run = 1'b1;
    tick(); check_eq("s5 still full", 32'(hif.in_ready), 32'd0);
    tick();
    check_eq("s5 issue 20", 32'(dut_instr), 32'h20);
    check_eq("s5 ready after pop", 32'(hif.in_ready), 32'd1);
    tick();
    check_eq("s5 issue 21", 32'(dut_instr), 32'h21);
    check_eq("s5 push+pop ready", 32'(hif.in_ready), 32'd1);
    hif.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("s5 drain%0d", i), 32'(dut_instr), 32'(drain_v[i]));
    end
    ctl_run = 1'b0;
    tick(); tick();
    push_instr(6'h31);
    push_instr(6'h32);
    push_instr(6'h33);
    io = 5'd5;
    ctl_run = 1'b1;
    tick(); tick();
    check_eq("s5 issue 31", 32'(dut_instr), 32'h31);
    check_eq("s5 trace pending", 32'(hif.tr_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("s5 mid-rst state", 32'(state_o), 32'd0);
    check_eq("s5 mid-rst dut_instr", 32'(dut_instr), 32'd0);
    check_eq("s5 mid-rst in_ready", 32'(hif.in_ready), 32'd1);
    check_eq("s5 mid-rst tr_valid", 32'(hif.tr_valid), 32'd0);
    check_eq("s5 mid-rst tr_data", 32'(hif.tr_data), 32'd0);
    check_eq("s5 mid-rst starve", 32'(starve_cnt), 32'd0);
    io = '0;
    #1;
    rst = 1'b1;
    tick(); tick();
    check_eq("s5 post-rst nop", 32'(dut_instr), 32'd0);
    check_eq("s5 post-rst starve", 32'(starve_cnt), 32'd1);
    check_eq("s5 post-rst no trace", 32'(hif.tr_valid), 32'd0);
    ctl_run = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
